id_ex_stage: RTL and testbench

//  ID/EX pipeline register plus EX-stage ALU of the 5-stage MIPS pipeline. It latches the

---
 rtl/id_ex_stage.sv | 143 ++++++++++++++
 tb/tb_id_ex_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register plus EX-stage ALU: latches the decoded instruction and the forwarded
// operands, then computes the EX result, the sw store data and the signed-overflow flag.
module id_ex_stage #(
  parameter int BUB_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_inst,
  input  logic [4:0]       id_rfDst,
  input  logic [31:0]      id_rs_val,
  input  logic [31:0]      id_rt_val,
  input  logic             ex_flush,
  input  logic             ex_hold,
  output logic [31:0]      ex_inst,
  output logic [4:0]       ex_rfDst,
  output logic [31:0]      ex_forwarding,
  output logic [31:0]      ex_rt_out,
  output logic             ex_ovf,
  output logic             ex_valid,
  output logic [BUB_W-1:0] bubble_cnt
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000, OP_ADDI  = 6'b001000, OP_ADDIU = 6'b001001,
    OP_SLTI  = 6'b001010, OP_SLTIU = 6'b001011, OP_ANDI  = 6'b001100,
    OP_ORI   = 6'b001101, OP_XORI  = 6'b001110, OP_LUI   = 6'b001111,
    OP_LW    = 6'b100011, OP_SW    = 6'b101011
  } opcode_e;

  typedef enum logic [5:0] {
    FN_SLL  = 6'b000000, FN_SRL  = 6'b000010, FN_SRA  = 6'b000011,
    FN_SLLV = 6'b000100, FN_SRLV = 6'b000110, FN_SRAV = 6'b000111,
    FN_ADD  = 6'b100000, FN_ADDU = 6'b100001, FN_SUB  = 6'b100010,
    FN_SUBU = 6'b100011, FN_AND  = 6'b100100, FN_OR   = 6'b100101,
    FN_XOR  = 6'b100110, FN_NOR  = 6'b100111, FN_SLT  = 6'b101010,
    FN_SLTU = 6'b101011
  } funct_e;

  logic [31:0] rs_q;
  logic [31:0] rt_q;

  // NOTE: pipeline state uses non-blocking assignments so every register samples its
  // inputs from before the edge; blocking here would create ordering-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_inst    <= '0;
      ex_rfDst   <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      ex_valid   <= 1'b0;
      bubble_cnt <= '0;
    end else if (ex_hold) begin
      // A pending flush is dropped while held: the held instruction stays in EX.
    end else if (ex_flush) begin
      ex_inst  <= '0;
      ex_rfDst <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      ex_valid <= 1'b0;
      if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + BUB_W'(1);
    end else begin
      ex_inst  <= id_inst;
      ex_rfDst <= id_rfDst;
      rs_q     <= id_rs_val;
      rt_q     <= id_rt_val;
      ex_valid <= 1'b1;
    end
  end

  assign ex_rt_out = rt_q;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [31:0] sum_rr;
  logic [31:0] diff_rr;
  logic [31:0] sum_ri;

  assign opcode   = ex_inst[31:26];
  assign funct    = ex_inst[5:0];
  assign shamt    = ex_inst[10:6];
  assign imm_sext = {{16{ex_inst[15]}}, ex_inst[15:0]};
  assign imm_zext = {16'h0000, ex_inst[15:0]};
  assign sum_rr   = rs_q + rt_q;
  assign diff_rr  = rs_q - rt_q;
  assign sum_ri   = rs_q + imm_sext;

  // NOTE: both outputs get a default before the case so no path leaves them unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    ex_forwarding = '0;
    ex_ovf        = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin
            ex_forwarding = sum_rr;
            ex_ovf = (rs_q[31] == rt_q[31]) && (sum_rr[31] != rs_q[31]);
          end
          FN_ADDU: ex_forwarding = sum_rr;
          FN_SUB: begin
            ex_forwarding = diff_rr;
            ex_ovf = (rs_q[31] != rt_q[31]) && (diff_rr[31] != rs_q[31]);
          end
          FN_SUBU: ex_forwarding = diff_rr;
          FN_AND:  ex_forwarding = rs_q & rt_q;
          FN_OR:   ex_forwarding = rs_q | rt_q;
          FN_XOR:  ex_forwarding = rs_q ^ rt_q;
          FN_NOR:  ex_forwarding = ~(rs_q | rt_q);
          FN_SLT:  ex_forwarding = {31'b0, $signed(rs_q) < $signed(rt_q)};
          FN_SLTU: ex_forwarding = {31'b0, rs_q < rt_q};
          FN_SLL:  ex_forwarding = rt_q << shamt;
          FN_SRL:  ex_forwarding = rt_q >> shamt;
          FN_SRA:  ex_forwarding = $unsigned($signed(rt_q) >>> shamt);
          FN_SLLV: ex_forwarding = rt_q << rs_q[4:0];
          FN_SRLV: ex_forwarding = rt_q >> rs_q[4:0];
          FN_SRAV: ex_forwarding = $unsigned($signed(rt_q) >>> rs_q[4:0]);
          default: ex_forwarding = '0;
        endcase
      end
      OP_ADDI: begin
        ex_forwarding = sum_ri;
        ex_ovf = (rs_q[31] == imm_sext[31]) && (sum_ri[31] != rs_q[31]);
      end
      OP_ADDIU, OP_LW, OP_SW: ex_forwarding = sum_ri;
      OP_SLTI:  ex_forwarding = {31'b0, $signed(rs_q) < $signed(imm_sext)};
      OP_SLTIU: ex_forwarding = {31'b0, rs_q < imm_sext};
      OP_ANDI:  ex_forwarding = rs_q & imm_zext;
      OP_ORI:   ex_forwarding = rs_q | imm_zext;
      OP_XORI:  ex_forwarding = rs_q ^ imm_zext;
      OP_LUI:   ex_forwarding = {ex_inst[15:0], 16'h0000};
      default:  ex_forwarding = '0;
    endcase
    // The all-zero word is a bubble, not "sll $0,$0,0" of a live rt operand.
    if (ex_inst == '0) begin
      ex_forwarding = '0;
      ex_ovf        = 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a cycle-level reference model checked every cycle, plus directed
// vectors with hand-computed results.
module tb_id_ex_stage;

  localparam int BUB_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      id_inst;
  logic [4:0]       id_rfDst;
  logic [31:0]      id_rs_val;
  logic [31:0]      id_rt_val;
  logic             ex_flush;
  logic             ex_hold;
  logic [31:0]      ex_inst;
  logic [4:0]       ex_rfDst;
  logic [31:0]      ex_forwarding;
  logic [31:0]      ex_rt_out;
  logic             ex_ovf;
  logic             ex_valid;
  logic [BUB_W-1:0] bubble_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  id_ex_stage #(.BUB_W(BUB_W)) dut (
    .clk(clk), .rst(rst), .id_inst(id_inst), .id_rfDst(id_rfDst),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .ex_flush(ex_flush), .ex_hold(ex_hold),
    .ex_inst(ex_inst), .ex_rfDst(ex_rfDst), .ex_forwarding(ex_forwarding),
    .ex_rt_out(ex_rt_out), .ex_ovf(ex_ovf), .ex_valid(ex_valid), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] r_type(input int rs, input int rt, input int rd,
                                         input int sh, input logic [5:0] fn);
    return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input int rs, input int rt,
                                         input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  // Reference ALU: 64-bit signed arithmetic decides overflow and signed compares.
  function automatic logic [32:0] model_alu(input logic [31:0] inst, input logic [31:0] rs,
                                            input logic [31:0] rt);
    logic [5:0]  op  = inst[31:26];
    logic [5:0]  fn  = inst[5:0];
    int          sh  = int'(inst[10:6]);
    int          vs  = int'(rs[4:0]);
    longint      a   = longint'($signed(rs));
    longint      b   = longint'($signed(rt));
    logic [31:0] se  = {{16{inst[15]}}, inst[15:0]};
    longint      c   = longint'($signed(se));
    logic [31:0] ones = 32'hFFFF_FFFF;
    longint      r   = 0;
    logic [31:0] res = 32'h0;
    logic        ovf = 1'b0;
    if (inst == 32'h0) return 33'h0;
    case (op)
      6'h00: case (fn)
        6'h20: begin r = a + b; res = r[31:0]; ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
        6'h21: res = rs + rt;
        6'h22: begin r = a - b; res = r[31:0]; ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
        6'h23: res = rs - rt;
        6'h24: res = rs & rt;
        6'h25: res = rs | rt;
        6'h26: res = rs ^ rt;
        6'h27: res = ~(rs | rt);
        6'h2A: res = (a < b) ? 32'd1 : 32'd0;
        6'h2B: res = (rs < rt) ? 32'd1 : 32'd0;
        6'h00: res = rt << sh;
        6'h02: res = rt >> sh;
        6'h03: res = (rt >> sh) | (rt[31] ? ~(ones >> sh) : 32'h0);
        6'h04: res = rt << vs;
        6'h06: res = rt >> vs;
        6'h07: res = (rt >> vs) | (rt[31] ? ~(ones >> vs) : 32'h0);
        default: res = 32'h0;
      endcase
      6'h08: begin r = a + c; res = r[31:0]; ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      6'h09, 6'h23, 6'h2B: res = rs + se;
      6'h0A: res = (a < c) ? 32'd1 : 32'd0;
      6'h0B: res = (rs < se) ? 32'd1 : 32'd0;
      6'h0C: res = rs & {16'h0, inst[15:0]};
      6'h0D: res = rs | {16'h0, inst[15:0]};
      6'h0E: res = rs ^ {16'h0, inst[15:0]};
      6'h0F: res = {inst[15:0], 16'h0};
      default: res = 32'h0;
    endcase
    return {ovf, res};
  endfunction

  // Cycle-level model of the EX register contents.
  logic [31:0] m_inst, m_rs, m_rt;
  logic [4:0]  m_dst;
  logic        m_valid;
  int          m_cnt;
  bit          cmp_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_inst <= 32'h0; m_dst <= 5'h0; m_rs <= 32'h0; m_rt <= 32'h0; m_valid <= 1'b0; m_cnt <= 0;
    end else if (ex_hold) begin
      m_cnt <= m_cnt;
    end else if (ex_flush) begin
      m_inst <= 32'h0; m_dst <= 5'h0; m_rs <= 32'h0; m_rt <= 32'h0; m_valid <= 1'b0;
      m_cnt  <= (m_cnt == (1 << BUB_W) - 1) ? m_cnt : m_cnt + 1;
    end else begin
      m_inst <= id_inst; m_dst <= id_rfDst; m_rs <= id_rs_val; m_rt <= id_rt_val; m_valid <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [32:0] exp_alu;
      exp_alu = model_alu(m_inst, m_rs, m_rt);
      check("cyc_inst",  ex_inst,              m_inst);
      check("cyc_dst",   {27'h0, ex_rfDst},    {27'h0, m_dst});
      check("cyc_fwd",   ex_forwarding,        exp_alu[31:0]);
      check("cyc_ovf",   {31'h0, ex_ovf},      {31'h0, exp_alu[32]});
      check("cyc_rt",    ex_rt_out,            m_rt);
      check("cyc_valid", {31'h0, ex_valid},    {31'h0, m_valid});
      check("cyc_bcnt",  {30'h0, bubble_cnt},  32'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input int dst, input logic [31:0] rs,
                       input logic [31:0] rt);
    id_inst = inst; id_rfDst = 5'(dst); id_rs_val = rs; id_rt_val = rt;
  endtask

  logic [5:0] ops[12] = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                          6'h23, 6'h2B, 6'h02};
  logic [5:0] fns[18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                          6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h01, 6'h3F};

  initial begin
    logic [31:0] ori_i, nxt_i, rnd_i;
    logic [31:0] corner[4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001};
    rst = 1'b1; ex_flush = 1'b0; ex_hold = 1'b0;
    drive(r_type(1, 2, 3, 0, 6'h21), 3, 32'h1234_5678, 32'h9ABC_DEF0);

    // 1: reset
    step(); step();
    cmp_en = 1'b1;
    check("rst_inst",  ex_inst, 32'h0);
    check("rst_fwd",   ex_forwarding, 32'h0);
    check("rst_valid", {31'h0, ex_valid}, 32'h0);
    check("rst_rt",    ex_rt_out, 32'h0);
    rst = 1'b0;
    step();
    check("rel_bcnt",  {30'h0, bubble_cnt}, 32'h0);

    // 2: add / addu overflow
    drive(r_type(1, 2, 3, 0, 6'h20), 3, 32'h7FFF_FFFF, 32'h0000_0001);
    step();
    check("add_fwd",   ex_forwarding, 32'h8000_0000);
    check("add_ovf",   {31'h0, ex_ovf}, 32'h1);
    check("add_dst",   {27'h0, ex_rfDst}, 32'd3);
    check("add_valid", {31'h0, ex_valid}, 32'h1);
    drive(r_type(1, 2, 3, 0, 6'h21), 3, 32'h7FFF_FFFF, 32'h0000_0001);
    step();
    check("addu_ovf",  {31'h0, ex_ovf}, 32'h0);

    // 3: lw address then flush
    drive(i_type(6'h23, 2, 5, 16'hFFFC), 5, 32'h0000_1000, 32'hDEAD_BEEF);
    step();
    check("lw_fwd", ex_forwarding, 32'h0000_0FFC);
    check("lw_dst", {27'h0, ex_rfDst}, 32'd5);
    ex_flush = 1'b1;
    step();
    ex_flush = 1'b0;
    check("fl_inst",  ex_inst, 32'h0);
    check("fl_dst",   {27'h0, ex_rfDst}, 32'h0);
    check("fl_valid", {31'h0, ex_valid}, 32'h0);
    check("fl_bcnt",  {30'h0, bubble_cnt}, 32'd1);

    // 4: hold beats flush
    ori_i = i_type(6'h0D, 1, 4, 16'h00F0);
    drive(ori_i, 4, 32'h0000_0F00, 32'h0);
    step();
    check("ori_fwd", ex_forwarding, 32'h0000_0FF0);
    nxt_i = r_type(7, 8, 9, 0, 6'h24);
    drive(nxt_i, 9, 32'hF0F0_F0F0, 32'hFF00_FF00);
    ex_hold = 1'b1; ex_flush = 1'b1;
    step(); step();
    check("hold_inst", ex_inst, ori_i);
    check("hold_fwd",  ex_forwarding, 32'h0000_0FF0);
    check("hold_bcnt", {30'h0, bubble_cnt}, 32'd1);
    ex_hold = 1'b0; ex_flush = 1'b0;
    step();
    check("unhold_inst", ex_inst, nxt_i);
    check("unhold_fwd",  ex_forwarding, 32'hF000_F000);

    // 5: immediates, shifts, compares, bubble and illegal encodings
    drive(r_type(0, 2, 6, 4, 6'h03), 6, 32'h0, 32'h8000_0000);   step();
    check("sra_fwd", ex_forwarding, 32'hF800_0000);
    drive(i_type(6'h0B, 1, 2, 16'hFFFF), 2, 32'd5, 32'h0);       step();
    check("sltiu_fwd", ex_forwarding, 32'h1);
    drive(i_type(6'h0F, 0, 2, 16'h1234), 2, 32'h5555_5555, 32'h0); step();
    check("lui_fwd", ex_forwarding, 32'h1234_0000);
    drive(i_type(6'h0C, 1, 2, 16'h8001), 2, 32'hFFFF_FFFF, 32'h0); step();
    check("andi_fwd", ex_forwarding, 32'h0000_8001);
    drive(r_type(1, 2, 3, 0, 6'h22), 3, 32'h8000_0000, 32'h1);   step();
    check("sub_fwd", ex_forwarding, 32'h7FFF_FFFF);
    check("sub_ovf", {31'h0, ex_ovf}, 32'h1);
    drive(i_type(6'h08, 1, 2, 16'h8000), 2, 32'h8000_0000, 32'h0); step();
    check("addi_ovf", {31'h0, ex_ovf}, 32'h1);
    drive(r_type(1, 2, 3, 0, 6'h2A), 3, 32'hFFFF_FFFF, 32'h1);   step();
    check("slt_fwd", ex_forwarding, 32'h1);
    drive(r_type(1, 2, 3, 0, 6'h06), 3, 32'h0000_0024, 32'h8000_0000); step();
    check("srlv_fwd", ex_forwarding, 32'h0800_0000);
    drive(32'h0, 0, 32'hAAAA_AAAA, 32'h5555_5555);               step();
    check("nop_fwd", ex_forwarding, 32'h0);
    drive(i_type(6'h02, 1, 2, 16'h1234), 2, 32'h1, 32'h1);       step();
    check("illegal_fwd", ex_forwarding, 32'h0);

    // Reset wins over hold
    ex_hold = 1'b1; rst = 1'b1; step();
    check("rsthold_inst", ex_inst, 32'h0);
    ex_hold = 1'b0;
    step();
    rst = 1'b0;

    // 6: counter saturation
    ex_flush = 1'b1;
    step(); check("sat_1", {30'h0, bubble_cnt}, 32'd1);
    step(); check("sat_2", {30'h0, bubble_cnt}, 32'd2);
    step(); check("sat_3", {30'h0, bubble_cnt}, 32'd3);
    step(); check("sat_4", {30'h0, bubble_cnt}, 32'd3);
    ex_flush = 1'b0;

    // Mixed traffic checked by the per-cycle model
    for (int i = 0; i < 300; i++) begin
      logic [5:0] op;
      op = ops[$urandom_range(0, 11)];
      rnd_i = $urandom;
      if (op == 6'h00) rnd_i = {6'h00, rnd_i[25:6], fns[$urandom_range(0, 17)]};
      else             rnd_i = {op, rnd_i[25:0]};
      drive(rnd_i, int'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom,
            ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom);
      ex_flush = ($urandom_range(0, 7) == 0);
      ex_hold  = ($urandom_range(0, 7) == 0);
      rst      = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0; ex_flush = 1'b0; ex_hold = 1'b0;
    step();

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
